// File: rtl/pipe_mat4_vec_seq_if.sv
// Request/response and dot-unit bundle for the mat4*vec sequencer.
// master = requester/dot-unit side, slave = the sequencer.
interface pipe_mat4_vec_seq_if;
  logic         start;
  logic [511:0] mat;
  logic [127:0] vec;
  logic         ready;
  logic         dot_clk_en;
  logic [31:0]  dot_v1;
  logic [31:0]  dot_v2;
  logic [31:0]  dot_result;
  logic [127:0] out_vec;
  logic         done;

  modport master (
    output start, mat, vec, dot_result,
    input  ready, dot_clk_en, dot_v1, dot_v2, out_vec, done
  );

  modport slave (
    input  start, mat, vec, dot_result,
    output ready, dot_clk_en, dot_v1, dot_v2, out_vec, done
  );
endinterface

// File: rtl/pipe_mat4_vec_seq.sv
// Streams M(r,c)/v(c) pairs to the serial dot unit on phase-0 group boundaries and gathers M*v; done 16+DOT_LATENCY after first issue.
// One request in flight: ready drops on accept, returns the cycle after done; start while busy is dropped.
module pipe_mat4_vec_seq #(
  parameter int DOT_LATENCY = 16
) (
  input logic                 clock,
  input logic                 aclr_n,
  pipe_mat4_vec_seq_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     phase_q, phase_d;
  logic [3:0]                     k_q, k_d;
  logic [511:0]                   mat_q, mat_d;
  logic [127:0]                   vec_q, vec_d;
  logic [DOT_LATENCY-1:0]         tag_vld_q, tag_vld_d;
  logic [DOT_LATENCY-1:0][1:0]    tag_row_q, tag_row_d;
  logic [3:0][31:0]               out_vec_q, out_vec_d;
  logic                           clk_en_q, clk_en_d;

  logic       issue;
  logic       tag_exit;
  logic [1:0] exit_row;

  assign issue    = (state_q == S_ISSUE);
  assign tag_exit = tag_vld_q[DOT_LATENCY-1];
  assign exit_row = tag_row_q[DOT_LATENCY-1];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 2'd1;
    k_d       = 4'd0;
    mat_d     = mat_q;
    vec_d     = vec_q;
    out_vec_d = out_vec_q;
    clk_en_d  = 1'b1;

    for (int i = DOT_LATENCY - 1; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_row_d[i] = tag_row_q[i-1];
    end
    // A row's tag enters with its last component; it exits when that row's result is on dot_result.
    tag_vld_d[0] = issue && (k_q[1:0] == 2'd3);
    tag_row_d[0] = k_q[3:2];

    if (tag_exit) begin
      out_vec_d[exit_row] = bus.dot_result;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mat_d   = bus.mat;
          vec_d   = bus.vec;
          state_d = (phase_q == 2'd3) ? S_ISSUE : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (phase_q == 2'd3) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tag_exit && (exit_row == 2'd3)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      k_q       <= 4'd0;
      mat_q     <= '0;
      vec_q     <= '0;
      tag_vld_q <= '0;
      tag_row_q <= '0;
      out_vec_q <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      mat_q     <= mat_d;
      vec_q     <= vec_d;
      tag_vld_q <= tag_vld_d;
      tag_row_q <= tag_row_d;
      out_vec_q <= out_vec_d;
      clk_en_q  <= clk_en_d;
    end
  end

  // Issue index k maps to mat bit offset 32*k and vec bit offset 32*(k&3).
  assign bus.dot_v1     = issue ? mat_q[{k_q, 5'b0} +: 32] : 32'd0;
  assign bus.dot_v2     = issue ? vec_q[{k_q[1:0], 5'b0} +: 32] : 32'd0;
  assign bus.ready      = (state_q == S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.out_vec    = out_vec_q;
  assign bus.dot_clk_en = clk_en_q;

endmodule
